d_to_ex_elastic_reg: RTL and testbench

Parametrised, elastic successor to the fixed decode-to-execute pipeline register. It replaces the zero-on-stall behaviour with a valid/ready handshake, an optional 2-entry skid buffer, and a separate flush input. It also provides a saturating bubble counter. It sits between decode and execute; the execute stage can now back-pressure decode without dropping instructions.

---
 rtl/d_to_ex_elastic_reg.sv | 155 +++++++++++++++
 tb/tb_d_to_ex_elastic_reg.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_to_ex_elastic_reg.sv
// ---------------------------------------------------------------------------
// d_to_ex_elastic_reg
//
// Elastic decode-to-execute pipeline register. Decode hands over an
// instruction with a valid/ready handshake; execute can back-pressure it
// without losing anything. With SKID=1 a second (skid) entry absorbs the
// instruction that is in flight when execute stalls, which lets D_ready be
// a pure decode of registered state. With SKID=0 there is a single entry and
// D_ready follows EX_ready combinationally. EX_taken flushes everything
// held, plus anything accepted at the same edge.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   D_valid / D_ready   decode-side handshake
//   D_ops, D_pc,        instruction payload from decode
//   D_alu_op, D_rd,
//   D_brn, D_ld,
//   D_str, D_we
//   EX_taken            flush request from execute
//   EX_ready            execute consumes the presented instruction
//   EX_valid, EX_*      instruction presented to execute (all 0 when idle)
//   bubble_cnt          saturating count of idle cycles since reset
// ---------------------------------------------------------------------------
module d_to_ex_elastic_reg #(
   parameter int XLEN = 32,
   parameter int NOPS = 4,
   parameter int OPW  = 4,
   parameter int RDW  = 5,
   parameter int SKID = 1,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 D_valid,
   output logic                 D_ready,
   input  logic [NOPS*XLEN-1:0] D_ops,
   input  logic [XLEN-1:0]      D_pc,
   input  logic [OPW-1:0]       D_alu_op,
   input  logic [RDW-1:0]       D_rd,
   input  logic                 D_brn,
   input  logic                 D_ld,
   input  logic                 D_str,
   input  logic                 D_we,
   input  logic                 EX_taken,
   input  logic                 EX_ready,
   output logic                 EX_valid,
   output logic [NOPS*XLEN-1:0] EX_ops,
   output logic [XLEN-1:0]      EX_pc,
   output logic [OPW-1:0]       EX_alu_op,
   output logic [RDW-1:0]       EX_rd,
   output logic                 EX_brn,
   output logic                 EX_ld,
   output logic                 EX_str,
   output logic                 EX_we,
   output logic [CNTW-1:0]      bubble_cnt
);

   typedef struct packed {
      logic [NOPS*XLEN-1:0] ops;
      logic [XLEN-1:0]      pc;
      logic [OPW-1:0]       alu_op;
      logic [RDW-1:0]       rd;
      logic                 brn;
      logic                 ld;
      logic                 str;
      logic                 we;
   } entry_t;

   // Number of live entries. TWO is only reachable when SKID=1.
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t          state_q;
   entry_t          main_q;
   entry_t          skid_q;
   entry_t          d_entry;
   logic [CNTW-1:0] bubble_cnt_q;
   logic            accept;
   logic            retire;

   assign d_entry = '{ops: D_ops, pc: D_pc, alu_op: D_alu_op, rd: D_rd,
                      brn: D_brn, ld: D_ld, str: D_str, we: D_we};

   assign EX_valid = (state_q != EMPTY);

   // SKID=1: ready depends only on the state register, so execute's stall
   // never ripples combinationally back into decode.
   assign D_ready = (SKID != 0) ? (state_q != TWO)
                                : ((state_q == EMPTY) | EX_ready);

   assign accept = D_valid & D_ready;
   assign retire = EX_valid & EX_ready;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state_q, main_q and skid_q.
      if (rst) begin
         state_q      <= EMPTY;
         main_q       <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (!EX_valid && (bubble_cnt_q != {CNTW{1'b1}}))
            bubble_cnt_q <= bubble_cnt_q + 1'b1;

         // main_q is kept at zero whenever empty, so EX outputs are driven
         // straight from the register and idle cycles look like a bubble.
         if (EX_taken) begin
            state_q <= EMPTY;
            main_q  <= '0;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (accept) begin
                     state_q <= ONE;
                     main_q  <= d_entry;
                  end
               end
               ONE: begin
                  if (accept && retire) begin
                     main_q <= d_entry;
                  end else if (accept) begin
                     // NOTE: skid_q is not reset; its contents only become
                     // visible after being copied into main_q from TWO.
                     state_q <= TWO;
                     skid_q  <= d_entry;
                  end else if (retire) begin
                     state_q <= EMPTY;
                     main_q  <= '0;
                  end
               end
               TWO: begin
                  if (retire) begin
                     state_q <= ONE;
                     main_q  <= skid_q;
                  end
               end
               default: begin
                  state_q <= EMPTY;
                  main_q  <= '0;
               end
            endcase
         end
      end
   end

   assign EX_ops     = main_q.ops;
   assign EX_pc      = main_q.pc;
   assign EX_alu_op  = main_q.alu_op;
   assign EX_rd      = main_q.rd;
   assign EX_brn     = main_q.brn;
   assign EX_ld      = main_q.ld;
   assign EX_str     = main_q.str;
   assign EX_we      = main_q.we;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_d_to_ex_elastic_reg.sv
// ---------------------------------------------------------------------------
// tb_d_to_ex_elastic_reg
//
// Directed bench for d_to_ex_elastic_reg. Two instances share all inputs:
// u_skid (SKID=1, CNTW=4) and u_noskid (SKID=0, CNTW=16). Each scenario
// starts from reset and checks only the instance it targets, except where
// both are meaningful.
// ---------------------------------------------------------------------------
module tb_d_to_ex_elastic_reg;

   localparam int XLEN = 32;
   localparam int NOPS = 4;
   localparam int OPW  = 4;
   localparam int RDW  = 5;
   localparam int OW   = NOPS * XLEN;

   logic            clk = 1'b0;
   logic            rst;
   logic            d_valid;
   logic [OW-1:0]   d_ops;
   logic [XLEN-1:0] d_pc;
   logic [OPW-1:0]  d_alu_op;
   logic [RDW-1:0]  d_rd;
   logic            d_brn, d_ld, d_str, d_we;
   logic            ex_taken, ex_ready;

   logic            s_d_ready, s_ex_valid, s_brn, s_ld, s_str, s_we;
   logic [OW-1:0]   s_ops;
   logic [XLEN-1:0] s_pc;
   logic [OPW-1:0]  s_alu_op;
   logic [RDW-1:0]  s_rd;
   logic [3:0]      s_bubble;

   logic            n_d_ready, n_ex_valid, n_brn, n_ld, n_str, n_we;
   logic [OW-1:0]   n_ops;
   logic [XLEN-1:0] n_pc;
   logic [OPW-1:0]  n_alu_op;
   logic [RDW-1:0]  n_rd;
   logic [15:0]     n_bubble;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   d_to_ex_elastic_reg #(.XLEN(XLEN), .NOPS(NOPS), .OPW(OPW), .RDW(RDW),
                         .SKID(1), .CNTW(4)) u_skid (
      .clk(clk), .rst(rst), .D_valid(d_valid), .D_ready(s_d_ready),
      .D_ops(d_ops), .D_pc(d_pc), .D_alu_op(d_alu_op), .D_rd(d_rd),
      .D_brn(d_brn), .D_ld(d_ld), .D_str(d_str), .D_we(d_we),
      .EX_taken(ex_taken), .EX_ready(ex_ready), .EX_valid(s_ex_valid),
      .EX_ops(s_ops), .EX_pc(s_pc), .EX_alu_op(s_alu_op), .EX_rd(s_rd),
      .EX_brn(s_brn), .EX_ld(s_ld), .EX_str(s_str), .EX_we(s_we),
      .bubble_cnt(s_bubble)
   );

   d_to_ex_elastic_reg #(.XLEN(XLEN), .NOPS(NOPS), .OPW(OPW), .RDW(RDW),
                         .SKID(0), .CNTW(16)) u_noskid (
      .clk(clk), .rst(rst), .D_valid(d_valid), .D_ready(n_d_ready),
      .D_ops(d_ops), .D_pc(d_pc), .D_alu_op(d_alu_op), .D_rd(d_rd),
      .D_brn(d_brn), .D_ld(d_ld), .D_str(d_str), .D_we(d_we),
      .EX_taken(ex_taken), .EX_ready(ex_ready), .EX_valid(n_ex_valid),
      .EX_ops(n_ops), .EX_pc(n_pc), .EX_alu_op(n_alu_op), .EX_rd(n_rd),
      .EX_brn(n_brn), .EX_ld(n_ld), .EX_str(n_str), .EX_we(n_we),
      .bubble_cnt(n_bubble)
   );

   // Operand pattern derived from the PC so every entry is distinguishable.
   function automatic logic [OW-1:0] mk_ops(input logic [XLEN-1:0] pc);
      return {pc ^ 32'hDEAD_BEEF, pc + 32'h1111_1111, ~pc, {pc[15:0], pc[31:16]}};
   endfunction

   task automatic check(input string tag, input logic [OW-1:0] obs,
                        input logic [OW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [XLEN-1:0] pc,
                        input logic [RDW-1:0] rd, input logic ld,
                        input logic we);
      d_valid  = v;
      d_pc     = pc;
      d_ops    = mk_ops(pc);
      d_rd     = rd;
      d_ld     = ld;
      d_we     = we;
      d_alu_op = pc[5:2];
      d_brn    = pc[2];
      d_str    = pc[3];
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      ex_taken = 1'b0;
      ex_ready = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // ---- reset state ----
      do_reset();
      check("rst_valid",  s_ex_valid, 0);
      check("rst_ready",  s_d_ready,  1);
      check("rst_ready0", n_d_ready,  1);
      check("rst_pc",     s_pc,       0);
      check("rst_bubble", s_bubble,   0);

      // ---- 1: first instruction appears right after the accepting edge ----
      ex_ready = 1'b1;
      drive(1'b1, 32'h100, 5'd3, 1'b0, 1'b1);
      tick();
      check("t1_valid",  s_ex_valid, 1);
      check("t1_pc",     s_pc,       32'h100);
      check("t1_rd",     s_rd,       3);
      check("t1_we",     s_we,       1);
      check("t1_bubble", s_bubble,   1);
      check("t1_pc0",    n_pc,       32'h100);
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      check("t1_drain",  s_ex_valid, 0);
      check("t1_rd_bub", s_rd,       0);
      check("t1_we_bub", s_we,       0);

      // ---- 2: skid fill, back-pressure, FIFO drain (SKID=1) ----
      do_reset();
      drive(1'b1, 32'h10, 5'd1, 1'b0, 1'b1);
      check("t2_rdy_a", s_d_ready, 1);
      tick();
      drive(1'b1, 32'h14, 5'd2, 1'b0, 1'b1);
      check("t2_rdy_b", s_d_ready, 1);
      tick();
      drive(1'b1, 32'h18, 5'd4, 1'b0, 1'b1);
      check("t2_rdy_c", s_d_ready, 0);
      tick();
      check("t2_hold_pc",  s_pc,  32'h10);
      check("t2_hold_ops", s_ops, mk_ops(32'h10));
      check("t2_rdy_full", s_d_ready, 0);
      ex_ready = 1'b1;
      tick();
      check("t2_pc_b",  s_pc,     32'h14);
      check("t2_ops_b", s_ops,    mk_ops(32'h14));
      check("t2_aop_b", s_alu_op, 4'h5);
      check("t2_rdy_1", s_d_ready, 1);
      tick();
      check("t2_pc_c",  s_pc,  32'h18);
      check("t2_ops_c", s_ops, mk_ops(32'h18));
      check("t2_rd_c",  s_rd,  4);
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      check("t2_empty", s_ex_valid, 0);

      // ---- 3: flush from TWO, then flush racing an accept ----
      do_reset();
      drive(1'b1, 32'h20, 5'd5, 1'b0, 1'b1);
      tick();
      drive(1'b1, 32'h24, 5'd6, 1'b0, 1'b1);
      tick();
      check("t3_two", s_d_ready, 0);
      drive(1'b1, 32'h28, 5'd7, 1'b1, 1'b1);
      ex_taken = 1'b1;
      tick();
      check("t3_valid", s_ex_valid, 0);
      check("t3_pc",    s_pc,       0);
      check("t3_ops",   s_ops,      0);
      check("t3_rd",    s_rd,       0);
      check("t3_ld",    s_ld,       0);
      check("t3_ready", s_d_ready,  1);
      tick();
      check("t3_race_valid", s_ex_valid, 0);
      check("t3_race_pc",    s_pc,       0);
      ex_taken = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      check("t3_after", s_ex_valid, 0);

      // ---- 4: stalled live load stays bit-stable ----
      do_reset();
      drive(1'b1, 32'h40, 5'd7, 1'b1, 1'b1);
      tick();
      drive(1'b0, 32'h44, 5'd9, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_valid",  s_ex_valid, 1);
         check("t4_rd",     s_rd,       7);
         check("t4_ld",     s_ld,       1);
         check("t4_pc",     s_pc,       32'h40);
         check("t4_bubble", s_bubble,   1);
      end

      // ---- 5: SKID=0 full throughput and combinational ready ----
      do_reset();
      ex_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h200 + 32'(4 * i), 5'(i + 1), 1'b0, 1'b1);
         check("t5_ready", n_d_ready, 1);
         tick();
         check("t5_valid", n_ex_valid, 1);
         check("t5_pc",    n_pc,  32'h200 + 32'(4 * i));
         check("t5_ops",   n_ops, mk_ops(32'h200 + 32'(4 * i)));
      end
      drive(1'b1, 32'h220, 5'd9, 1'b0, 1'b1);
      ex_ready = 1'b0;
      #1;
      check("t5_ready_drop", n_d_ready, 0);
      tick();
      check("t5_hold_pc", n_pc, 32'h21C);
      check("t5_hold_rd", n_rd, 8);
      ex_ready = 1'b1;
      #1;
      check("t5_ready_back", n_d_ready, 1);

      // ---- 6: bubble counter saturation, reset from TWO ----
      do_reset();
      for (int i = 0; i < 20; i++) tick();
      check("t6_sat",     s_bubble, 15);
      check("t6_nosat",   n_bubble, 20);
      drive(1'b1, 32'h300, 5'd1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 32'h304, 5'd2, 1'b0, 1'b1);
      tick();
      check("t6_two",     s_d_ready, 0);
      check("t6_sat_hold", s_bubble, 15);
      rst = 1'b1;
      tick();
      check("t6_rst_valid",  s_ex_valid, 0);
      check("t6_rst_pc",     s_pc,       0);
      check("t6_rst_bubble", s_bubble,   0);
      check("t6_rst_ready",  s_d_ready,  1);
      check("t6_rst_bub0",   n_bubble,   0);
      rst = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      check("t6_count_on", s_bubble, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
